bridge_cmd_sequencer: RTL

//  Sequences deframed UART command packets onto the bus bridge master port.

---
 rtl/bridge_pkg.sv | 28 ++
 rtl/bridge_cmd_fifo.sv | 67 ++++++
 rtl/bridge_cmd_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and packet field layout for the UART-to-bus command sequencer.
// Packet layout is {mode, data[7:0], addr[11:0]}; mode 1 = write, 0 = read.
package bridge_pkg;

    localparam int PKT_W    = 21;
    localparam int MODE_BIT = 20;
    localparam int DATA_MSB = 19;
    localparam int DATA_LSB = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 0;

    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        RESP
    } seq_state_e;

    function automatic logic pkt_is_write(input logic [PKT_W-1:0] pkt);
        return pkt[MODE_BIT] == MODE_WR;
    endfunction

endpackage

// File: rtl/bridge_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// A push into an empty FIFO becomes visible to the reader one cycle later.
module bridge_cmd_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/bridge_cmd_sequencer.sv
// Issues buffered UART command packets over the bridge req/grant/ack bus and returns read bytes.
// Optional bus timeout abort is enabled by defining BRIDGE_SEQ_BUS_TIMEOUT_EN.
module bridge_cmd_sequencer
    import bridge_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic [DATA_W+ADDR_W:0]   pkt_data,
    output logic                     mst_req,
    input  logic                     mst_grant,
    output logic                     mst_mode,
    output logic [ADDR_W-1:0]        mst_addr,
    output logic [DATA_W-1:0]        mst_wdata,
    input  logic                     mst_ack,
    input  logic [DATA_W-1:0]        mst_rdata,
    output logic                     tx_valid,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     err
);

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_rdata;

    seq_state_e        state_q, state_d;
    logic [PKT_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    bridge_cmd_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (pkt_valid && pkt_ready),
        .pop   (fifo_pop),
        .wdata (pkt_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    assign timeout_hit = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;
`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
        tmr_d     = tmr_q;
        err_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_rdata;
                    state_d  = REQ;
`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
                    tmr_d    = '0;
`endif
                end
            end
            REQ: begin
                if (mst_grant) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (mst_ack) begin
                    if (pkt_is_write(cmd_q)) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d = mst_rdata;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
        // An ack arriving in the final cycle still wins over the abort.
        if (state_q == REQ || state_q == XFER) begin
            tmr_d = tmr_q + TMR_W'(1);
            if (timeout_hit && !(state_q == XFER && mst_ack)) begin
                err_d = 1'b1;
                if (pkt_is_write(cmd_q)) begin
                    state_d = IDLE;
                end else begin
                    tx_data_d = DATA_W'(TIMEOUT_RDATA);
                    state_d   = RESP;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            tx_data_q <= '0;
`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
            tmr_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tx_data_q <= tx_data_d;
`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
            tmr_q     <= tmr_d;
            err_q     <= err_d;
`endif
        end
    end

    assign pkt_ready = !fifo_full;
    assign mst_req   = (state_q == REQ) || (state_q == XFER);
    assign mst_mode  = cmd_q[MODE_BIT];
    assign mst_addr  = cmd_q[ADDR_MSB:ADDR_LSB];
    assign mst_wdata = cmd_q[DATA_MSB:DATA_LSB];
    assign tx_valid  = (state_q == RESP);
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef BRIDGE_SEQ_BUS_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
